// File: rtl/megabytebeat_pkg.sv
// Shared constants for the bytebeat audio path: PCM width, midscale level and FSM state codes.
package megabytebeat_pkg;

   localparam int PCM_W = 8;
   localparam logic [PCM_W-1:0] PCM_MIDSCALE = 8'h80;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] EMIT = 2'd2;

endpackage

// File: rtl/sample_tick_gen.sv
// Reloadable down-counter producing the sample-rate tick.
// A tick fires when the count reaches zero. The counter then reloads div, so the period is
// div+1 cycles. A new div is only picked up at the next reload.
module sample_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] count;

   assign tick = (count == '0);

   // Count down and reload on the tick cycle. Reset to zero so the first tick follows reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      if (!rst_n)
         count <= '0;
      else if (tick)
         count <= div;
      else
         count <= count - DIV_W'(1);
   end

endmodule

// File: rtl/bytebeat_mix_scheduler.sv
// Sample-rate scheduler and mixer between the bytebeat generator bank and one pwm_audio output.
// Each tick starts a scan that visits every voice once in index order and pulls one byte from
// each enabled voice. A voice that stalls for TIMEOUT cycles is replaced by its last good byte,
// so the scan length is bounded. The mixed result is held on sample and announced by sample_stb.
module bytebeat_mix_scheduler
   import megabytebeat_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int DIV_W      = 16,
   parameter int TIMEOUT    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DIV_W-1:0]            sample_div,
   input  logic [NUM_VOICES-1:0]       voice_en,
   input  logic                        mix_mode,
   input  logic [PCM_W*NUM_VOICES-1:0] pcm,
   input  logic [NUM_VOICES-1:0]       pcm_vld,
   output logic [NUM_VOICES-1:0]       pcm_rdy,
   output logic [PCM_W-1:0]            sample,
   output logic                        sample_stb,
   output logic                        overrun,
   output logic                        busy
);

   localparam int IDX_W  = $clog2(NUM_VOICES);
   localparam int ACC_W  = PCM_W + IDX_W;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VOICES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [ACC_W-1:0]  PCM_MAX   = ACC_W'({PCM_W{1'b1}});

   logic [1:0]            state;
   logic [IDX_W-1:0]      idx;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [ACC_W-1:0]      acc;
   logic [NUM_VOICES-1:0] en_q;
   logic                  mode_q;
   logic [PCM_W-1:0]      held [NUM_VOICES];
   logic [PCM_W-1:0]      mix_result;
   logic                  tick;

   logic [PCM_W-1:0] cur_pcm;
   logic             cur_en;
   logic             cur_vld;
   logic             timed_out;
   logic             take_new;
   logic             take_held;
   logic             step;

   sample_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .div   (sample_div),
      .tick  (tick)
   );

   // Decode the voice currently being visited.
   assign cur_pcm   = pcm[PCM_W*idx +: PCM_W];
   assign cur_en    = en_q[idx];
   assign cur_vld   = pcm_vld[idx];
   assign timed_out = (wait_cnt == WAIT_LAST);
   assign take_new  = (state == SCAN) && cur_en && cur_vld;
   assign take_held = (state == SCAN) && cur_en && !cur_vld && timed_out;
   assign step      = (state == SCAN) && (!cur_en || cur_vld || timed_out);

   assign busy = (state != IDLE);

   // Ready is a pure decode of state and index, so it is one-hot by construction.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      pcm_rdy = '0;
      if (state == SCAN && cur_en)
         pcm_rdy[idx] = 1'b1;
   end

   // Mix rule applied at EMIT: midscale for an empty mask, else average or saturating sum.
   always_comb begin
      mix_result = PCM_MIDSCALE;
      if (en_q != '0) begin
         if (mode_q)
            mix_result = (acc > PCM_MAX) ? {PCM_W{1'b1}} : acc[PCM_W-1:0];
         else
            mix_result = PCM_W'(acc >> IDX_W);
      end
   end

   // Keep each voice's last accepted byte as the substitute for a stalled voice.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: this small array is reset explicitly because a stalled voice can read it before any real byte arrives.
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++)
            held[i] <= PCM_MIDSCALE;
      end else if (take_new) begin
         held[idx] <= cur_pcm;
      end
   end

   // Scheduler FSM: IDLE waits for a tick, SCAN visits each voice once, EMIT publishes the mix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         wait_cnt   <= '0;
         acc        <= '0;
         en_q       <= '0;
         mode_q     <= 1'b0;
         sample     <= PCM_MIDSCALE;
         sample_stb <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sample_stb <= 1'b0;
         if (tick && state != IDLE)
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (tick) begin
                  en_q     <= voice_en;
                  mode_q   <= mix_mode;
                  acc      <= '0;
                  idx      <= '0;
                  wait_cnt <= '0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (take_new)
                  acc <= acc + ACC_W'(cur_pcm);
               else if (take_held)
                  acc <= acc + ACC_W'(held[idx]);

               if (step) begin
                  wait_cnt <= '0;
                  if (idx == LAST_IDX)
                     state <= EMIT;
                  else
                     idx <= idx + IDX_W'(1);
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            EMIT: begin
               sample     <= mix_result;
               sample_stb <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
